// File: rtl/sdram_arb_pkg.sv
// Shared constants and helpers for the SDRAM port arbiter.
package sdram_arb_pkg;

  localparam int NPORTS = 3;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 8;

  // Grant encoding: a port index, or GNT_NONE for an idle (refresh) slot.
  typedef logic [1:0] gnt_t;

  localparam gnt_t P_CPU    = 2'd0;
  localparam gnt_t P_LOAD   = 2'd1;
  localparam gnt_t P_TAPE   = 2'd2;
  localparam gnt_t GNT_NONE = 2'd3;

  // One-hot acknowledge vector for a grant; idle maps to no bits set.
  function automatic logic [NPORTS-1:0] gnt_onehot(input gnt_t g);
    logic [NPORTS-1:0] v;
    case (g)
      P_CPU:   v = 3'b001;
      P_LOAD:  v = 3'b010;
      P_TAPE:  v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sdram_slot_timer.sv
// Slot timing: detects clkref rising edges and counts the phase within a slot.
module sdram_slot_timer (
  input  logic       clk,
  input  logic       init,
  input  logic       clkref,
  output logic       boundary,
  output logic [2:0] ph
);

  logic       clkref_d_r;
  logic [2:0] ph_r;

  // The boundary is the cycle in which the rising edge of clkref is seen.
  assign boundary = clkref & ~clkref_d_r;
  assign ph       = ph_r;

  // Edge-detect register and phase counter that parks at 7 if clkref stops.
  always_ff @(posedge clk) begin
    if (init) begin
      clkref_d_r <= 1'b0;
      ph_r       <= 3'd7;
    end else begin
      clkref_d_r <= clkref;
      if (boundary) begin
        ph_r <= 3'd0;
      end else if (ph_r != 3'd7) begin
        ph_r <= ph_r + 3'd1;
      end else begin
        ph_r <= ph_r;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Three-way arbiter for the SDRAM access port: one access per clkref slot,
// CPU priority with starvation relief for loader/tape, and guaranteed idle
// slots so the controller can auto-refresh.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int CAPTURE_PHASE = 6,
  parameter int STARVE_LIMIT  = 4,
  parameter int REFRESH_SLOTS = 64
) (
  input  logic                     clk,
  input  logic                     init,
  input  logic                     clkref,
  input  logic [NPORTS-1:0]        req,
  input  logic [NPORTS-1:0]        wr,
  input  logic [NPORTS*ADDR_W-1:0] addr,
  input  logic [NPORTS*DATA_W-1:0] din,
  output logic [DATA_W-1:0]        dout,
  output logic [NPORTS-1:0]        ack,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_din,
  input  logic [DATA_W-1:0]        ram_dout,
  output logic                     ram_oe,
  output logic                     ram_we
);

  localparam int RW = (REFRESH_SLOTS > 1) ? $clog2(REFRESH_SLOTS) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_SLOTS - 1);
  localparam logic [SW-1:0] STARVE_MAX  = SW'(STARVE_LIMIT);
  localparam logic [2:0]    CAP_PH      = 3'(CAPTURE_PHASE);

  logic              boundary_s;
  logic [2:0]        ph_s;
  logic              lower_req_s;
  gnt_t              lower_pick_s;
  gnt_t              next_gnt_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_din_s;
  logic              sel_wr_s;

  gnt_t              gnt_r;
  logic [RW-1:0]     refresh_cnt_r;
  logic [SW-1:0]     starve_r;
  logic              rr_ptr_r;  // 0: loader preferred, 1: tape preferred

  sdram_slot_timer u_timer (
    .clk      (clk),
    .init     (init),
    .clkref   (clkref),
    .boundary (boundary_s),
    .ph       (ph_s)
  );

  assign lower_req_s = |req[2:1];

  // Round-robin choice between loader and tape.
  always_comb begin
    lower_pick_s = P_LOAD;
    if (req[1] && req[2]) begin
      lower_pick_s = rr_ptr_r ? P_TAPE : P_LOAD;
    end else if (req[2]) begin
      lower_pick_s = P_TAPE;
    end else begin
      lower_pick_s = P_LOAD;
    end
  end

  // Grant decision for the coming slot, highest priority first.
  always_comb begin
    next_gnt_s = GNT_NONE;
    if (refresh_cnt_r == REFRESH_MAX) begin
      next_gnt_s = GNT_NONE;
    end else if ((starve_r == STARVE_MAX) && lower_req_s) begin
      next_gnt_s = lower_pick_s;
    end else if (req[0]) begin
      next_gnt_s = P_CPU;
    end else if (lower_req_s) begin
      next_gnt_s = lower_pick_s;
    end else begin
      next_gnt_s = GNT_NONE;
    end
  end

  // Route the chosen requester's address, data and direction.
  always_comb begin
    sel_addr_s = {ADDR_W{1'b0}};
    sel_din_s  = {DATA_W{1'b0}};
    sel_wr_s   = 1'b0;
    case (next_gnt_s)
      P_CPU: begin
        sel_addr_s = addr[ADDR_W-1:0];
        sel_din_s  = din[DATA_W-1:0];
        sel_wr_s   = wr[0];
      end
      P_LOAD: begin
        sel_addr_s = addr[2*ADDR_W-1:ADDR_W];
        sel_din_s  = din[2*DATA_W-1:DATA_W];
        sel_wr_s   = wr[1];
      end
      P_TAPE: begin
        sel_addr_s = addr[3*ADDR_W-1:2*ADDR_W];
        sel_din_s  = din[3*DATA_W-1:2*DATA_W];
        sel_wr_s   = wr[2];
      end
      default: begin
        sel_addr_s = {ADDR_W{1'b0}};
        sel_din_s  = {DATA_W{1'b0}};
        sel_wr_s   = 1'b0;
      end
    endcase
  end

  // Slot registers, fairness counters, read capture and acknowledge pulse.
  always_ff @(posedge clk) begin
    if (init) begin
      gnt_r         <= GNT_NONE;
      ram_addr      <= {ADDR_W{1'b0}};
      ram_din       <= {DATA_W{1'b0}};
      ram_oe        <= 1'b0;
      ram_we        <= 1'b0;
      dout          <= {DATA_W{1'b0}};
      ack           <= 3'b000;
      refresh_cnt_r <= {RW{1'b0}};
      starve_r      <= {SW{1'b0}};
      rr_ptr_r      <= 1'b0;
    end else begin
      ack <= 3'b000;

      if (boundary_s) begin
        gnt_r <= next_gnt_s;
        if (next_gnt_s != GNT_NONE) begin
          ram_addr      <= sel_addr_s;
          ram_din       <= sel_din_s;
          ram_oe        <= ~sel_wr_s;
          ram_we        <= sel_wr_s;
          refresh_cnt_r <= refresh_cnt_r + {{(RW-1){1'b0}}, 1'b1};
        end else begin
          // Idle slot: address/data hold, controller is free to refresh.
          ram_oe        <= 1'b0;
          ram_we        <= 1'b0;
          refresh_cnt_r <= {RW{1'b0}};
        end

        if (!lower_req_s) begin
          starve_r <= {SW{1'b0}};
        end else if (next_gnt_s == P_CPU) begin
          if (starve_r != STARVE_MAX) begin
            starve_r <= starve_r + {{(SW-1){1'b0}}, 1'b1};
          end
        end else if ((next_gnt_s == P_LOAD) || (next_gnt_s == P_TAPE)) begin
          starve_r <= {SW{1'b0}};
        end

        if (next_gnt_s == P_LOAD) begin
          rr_ptr_r <= 1'b1;
        end else if (next_gnt_s == P_TAPE) begin
          rr_ptr_r <= 1'b0;
        end
      end

      // Completion fires once per slot because ph passes CAP_PH only once.
      if ((ph_s == CAP_PH) && (gnt_r != GNT_NONE)) begin
        ack <= gnt_onehot(gnt_r);
        if (ram_oe) begin
          dout <= ram_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: one default instance plus one with a
// short refresh interval; clkref is an 8-clk square wave driven per cycle.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        init = 1'b0;
  logic        clkref = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [2:0]  wr = 3'b000;
  logic [74:0] addr = 75'd0;
  logic [23:0] din = 24'd0;
  logic [7:0]  ram_dout = 8'd0;

  logic [7:0]  dout, r_dout;
  logic [2:0]  ack, r_ack;
  logic [24:0] ram_addr, r_ram_addr;
  logic [7:0]  ram_din, r_ram_din;
  logic        ram_oe, ram_we, r_ram_oe, r_ram_we;

  sdram_arbiter dut (
    .clk(clk), .init(init), .clkref(clkref), .req(req), .wr(wr),
    .addr(addr), .din(din), .dout(dout), .ack(ack),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_oe(ram_oe), .ram_we(ram_we)
  );

  sdram_arbiter #(.REFRESH_SLOTS(8)) dut_r (
    .clk(clk), .init(init), .clkref(clkref), .req(req), .wr(wr),
    .addr(addr), .din(din), .dout(r_dout), .ack(r_ack),
    .ram_addr(r_ram_addr), .ram_din(r_ram_din), .ram_dout(ram_dout),
    .ram_oe(r_ram_oe), .ram_we(r_ram_we)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Per-slot observations (grant sampled right after the boundary edge).
  logic [24:0] s_addr;
  logic [7:0]  s_din;
  logic        s_oe, s_we, s_held;
  logic [2:0]  s_acks;
  int          s_nack, s_ack_idx;
  logic        r_oe_s, r_we_s;
  int          r_nack;

  // Runs one 8-clk slot; assumes clkref was raised just before the boundary edge.
  task automatic do_slot();
    s_acks = 3'b000; s_nack = 0; s_ack_idx = -1; s_held = 1'b1; r_nack = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        s_addr = ram_addr; s_din = ram_din; s_oe = ram_oe; s_we = ram_we;
        r_oe_s = r_ram_oe; r_we_s = r_ram_we;
      end else if (ram_addr !== s_addr || ram_oe !== s_oe || ram_we !== s_we) begin
        s_held = 1'b0;
      end
      if (ack != 3'b000) begin
        s_acks = s_acks | ack;
        s_nack += $countones(ack);
        if (s_ack_idx < 0) s_ack_idx = i;
      end
      if (r_ack != 3'b000) r_nack += $countones(r_ack);
      clkref = (i == 7 || i < 3);
    end
  endtask

  task automatic arm();
    @(negedge clk);
    clkref = 1'b1;
  endtask

  task automatic do_init();
    @(negedge clk);
    init = 1'b1;
    clkref = 1'b0;
    @(negedge clk);
    init = 1'b0;
  endtask

  int exp_seq [20] = '{0,0,0,0,1,0,0,0,0,2,0,0,0,0,1,0,0,0,0,2};
  int cnt;

  initial begin
    // Reset state
    do_init();
    check_val("rst_oe",   32'(ram_oe),   32'd0);
    check_val("rst_we",   32'(ram_we),   32'd0);
    check_val("rst_addr", 32'(ram_addr), 32'd0);
    check_val("rst_din",  32'(ram_din),  32'd0);
    check_val("rst_dout", 32'(dout),     32'd0);
    check_val("rst_ack",  32'(ack),      32'd0);
    check_val("rst_r_addr", 32'(r_ram_addr), 32'd0);
    check_val("rst_r_din",  32'(r_ram_din),  32'd0);
    check_val("rst_r_dout", 32'(r_dout),     32'd0);

    // CPU read
    req = 3'b001; wr = 3'b000; addr[24:0] = 25'h0004000; ram_dout = 8'hA5;
    arm();
    do_slot();
    check_val("rd_oe",     32'(s_oe),      32'd1);
    check_val("rd_we",     32'(s_we),      32'd0);
    check_val("rd_addr",   32'(s_addr),    32'h0004000);
    check_val("rd_ack",    32'(s_acks),    32'b001);
    check_val("rd_nack",   32'(s_nack),    32'd1);
    check_val("rd_ackidx", 32'(s_ack_idx), 32'd7);
    check_val("rd_dout",   32'(dout),      32'hA5);
    check_val("rd_held",   32'(s_held),    32'd1);

    // Idle slot after the requester dropped req
    req = 3'b000;
    do_slot();
    check_val("idle_oe",   32'(s_oe),   32'd0);
    check_val("idle_we",   32'(s_we),   32'd0);
    check_val("idle_addr", 32'(s_addr), 32'h0004000);
    check_val("idle_nack", 32'(s_nack), 32'd0);

    // Loader write to the top address
    req = 3'b010; wr = 3'b010; addr[49:25] = 25'h1FFFFFF; din[15:8] = 8'h3C; ram_dout = 8'h77;
    do_slot();
    check_val("wr_we",   32'(s_we),   32'd1);
    check_val("wr_oe",   32'(s_oe),   32'd0);
    check_val("wr_addr", 32'(s_addr), 32'h1FFFFFF);
    check_val("wr_din",  32'(s_din),  32'h3C);
    check_val("wr_ack",  32'(s_acks), 32'b010);
    check_val("wr_nack", 32'(s_nack), 32'd1);
    check_val("wr_dout", 32'(dout),   32'hA5);
    req = 3'b000; wr = 3'b000;

    // Contention: all three requesting
    do_init();
    req = 3'b111;
    addr[24:0] = 25'h100; addr[49:25] = 25'h101; addr[74:50] = 25'h102;
    arm();
    for (int k = 0; k < 20; k++) begin
      do_slot();
      check_val($sformatf("cont_port%0d", k), 32'(s_addr) - 32'h100, 32'(exp_seq[k]));
      check_val($sformatf("cont_ack%0d", k),  32'(s_acks), 32'd1 << exp_seq[k]);
    end

    // Refresh guarantee on the short-interval instance
    do_init();
    req = 3'b001; addr[24:0] = 25'h200;
    arm();
    for (int k = 0; k < 16; k++) begin
      do_slot();
      check_val($sformatf("ref_oe%0d", k),   32'(r_oe_s), (k % 8 == 7) ? 32'd0 : 32'd1);
      check_val($sformatf("ref_we%0d", k),   32'(r_we_s), 32'd0);
      check_val($sformatf("ref_nack%0d", k), 32'(r_nack), (k % 8 == 7) ? 32'd0 : 32'd1);
    end

    // Init in the middle of a granted read
    do_init();
    req = 3'b001; addr[24:0] = 25'h123; ram_dout = 8'h11;
    arm();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) check_val("mid_oe_pre", 32'(ram_oe), 32'd1);
      clkref = (i < 3);
    end
    init = 1'b1;
    @(negedge clk);
    check_val("mid_oe_post", 32'(ram_oe), 32'd0);
    init = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack != 3'b000) cnt++;
    end
    check_val("mid_noack", 32'(cnt),  32'd0);
    check_val("mid_dout",  32'(dout), 32'd0);
    arm();
    do_slot();
    check_val("mid_regrant_addr", 32'(s_addr), 32'h123);
    check_val("mid_regrant_ack",  32'(s_acks), 32'b001);
    check_val("mid_regrant_dout", 32'(dout),   32'h11);

    // clkref stops after a grant
    addr[24:0] = 25'h456; ram_dout = 8'h5A;
    cnt = 0;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      if (ack != 3'b000) cnt += $countones(ack);
      clkref = (i < 3);
    end
    check_val("stop_nack", 32'(cnt),      32'd1);
    check_val("stop_oe",   32'(ram_oe),   32'd1);
    check_val("stop_addr", 32'(ram_addr), 32'h456);
    check_val("stop_dout", 32'(dout),     32'h5A);
    arm();
    do_slot();
    check_val("stop_next_ack", 32'(s_acks), 32'b001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
